core_control_fsm: RTL and testbench
===================================

// Module: core_control_fsm
// PURPOSE
//  Multi-cycle sequencer for the RV32I datapath: fetch, decode, register file, ALU, data-memory port.
//  Owns the architectural PC and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
//  Drives the per-stage enables and write-back select, and resolves branch/jump targets.
//  Traps illegal opcodes, misaligned targets and memory timeouts into a sticky FAULT state.
// PARAMETERS
//  RESET_PC     32'h0  PC value loaded on reset
//  MEM_TIMEOUT  8      max MEM cycles without mem_ready before FAULT (>=1)
// PORTS
//  clk          in   1   clock, all state on rising edge
//  reset        in   1   synchronous, active-low
//  opcode       in   7   decoded instr[6:0], valid from EXEC onward
//  taken_br     in   1   ALU branch outcome, valid in WB
//  imm          in   32  decoded immediate, valid from EXEC onward
//  alu_result   in   32  ALU result, valid in WB (and MEM for address)
//  mem_ready    in   1   data memory completes current request
//  pc           out  32  architectural PC (instruction address)
//  fetch_en     out  1   capture instruction memory output
//  decode_en    out  1   capture decoder outputs
//  alu_en       out  1   ALU evaluates this cycle
//  mem_req      out  1   data memory request, held until mem_ready
//  mem_we       out  1   request is a store
//  rf_wr_en     out  1   register file write strobe
//  wb_sel       out  2   00 ALU, 01 load data, 10 pc+4, 11 imm
//  state        out  3   current state encoding (debug)
//  fault        out  1   sticky trap flag
// BEHAVIOUR
//  Reset (reset==0 at edge): state=IDLE, pc=RESET_PC, fault=0; dominates any state incl. MEM mid-request.
//  Strobes/wb_sel/mem_we are Moore decodes of state (+ latched opcode class); all 0 in IDLE and FAULT.
//  States: IDLE -> FETCH (unconditional, one cycle after reset release).
//   FETCH: fetch_en=1 -> DECODE.  DECODE: decode_en=1 -> EXEC.
//   EXEC: alu_en=1; latch opcode class; illegal opcode -> FAULT; load/store -> MEM; else -> WB.
//   MEM: mem_req=1, mem_we=store; mem_ready=1 -> load: WB, store: FETCH (pc update).
//        Wait counter counts MEM cycles; reaching MEM_TIMEOUT with mem_ready=0 -> FAULT.
//        mem_ready in first MEM cycle allowed (1-cycle access); mem_ready outside MEM ignored.
//   WB: rf_wr_en=1 except branch; pc update; -> FETCH (or FAULT if target misaligned).
//   FAULT: absorbing until reset; pc frozen at faulting instruction.
//  Opcode classes: LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111,
//   LUI 0110111, AUIPC 0010111, OPIMM 0010011, OP 0110011; anything else illegal.
//  wb_sel: LOAD 01, JAL/JALR 10, LUI 11, others 00.
//  Next PC (mod 2^32, wraps silently): BRANCH&taken_br or JAL: pc+imm; JALR: {alu_result[31:1],1'b0};
//   else pc+4. Target with bit[1]==1 -> FAULT, pc not updated, rf_wr_en suppressed that cycle.
//  Latency (no wait states): OP/OPIMM/LUI/AUIPC/JAL/JALR/BRANCH 4 cycles; STORE 4; LOAD 5; +1 per wait.
//  No overlap: next FETCH begins only after current instruction's pc update.
// STRUCTURE
//  Package core_ctrl_pkg: state encodings (IDLE..FAULT, 3 bits), opcode class constants,
//   wb_sel codes; shared with decoder and bench.
//  Sub-module next_pc_unit: combinational next-PC mux + misalignment flag; FSM, counter, pc register here.
// TESTING
//  ADDI x1,x0,21 at pc 0, reset released -> IDLE,FETCH,DECODE,EXEC,WB; rf_wr_en=1 wb_sel=00 in WB; pc=4.
//  BEQ imm=+8 at pc 0x10, taken_br=1 -> pc=0x18, rf_wr_en=0; taken_br=0 -> pc=0x14.
//  JAL imm=0x100 at pc 0x1c -> wb_sel=10 rf_wr_en=1, pc=0x11c; imm=0x102 -> fault=1, pc stays 0x1c.
//  SW, mem_ready after 3 MEM cycles -> mem_req high 3 cycles, mem_we=1, then FETCH with pc+4.
//  LW, mem_ready never, MEM_TIMEOUT=8 -> FAULT after 8 MEM cycles, mem_req=0 afterwards, sticky.
//  Opcode 7'b1111111 -> FAULT from EXEC; reset low mid-MEM -> next edge IDLE, pc=RESET_PC, mem_req=0.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the RV32I control sequencer: state encodings, opcode
// classes, write-back select codes and the opcode classifier.
`timescale 1ns/1ps
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'd0,
    CLS_LOAD    = 4'd1,
    CLS_STORE   = 4'd2,
    CLS_BRANCH  = 4'd3,
    CLS_JAL     = 4'd4,
    CLS_JALR    = 4'd5,
    CLS_LUI     = 4'd6,
    CLS_AUIPC   = 4'd7,
    CLS_OPIMM   = 4'd8,
    CLS_OP      = 4'd9
  } cls_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b11;

  function automatic cls_e classify(input logic [6:0] opc);
    case (opc)
      OPC_LOAD:   return CLS_LOAD;
      OPC_STORE:  return CLS_STORE;
      OPC_BRANCH: return CLS_BRANCH;
      OPC_JAL:    return CLS_JAL;
      OPC_JALR:   return CLS_JALR;
      OPC_LUI:    return CLS_LUI;
      OPC_AUIPC:  return CLS_AUIPC;
      OPC_OPIMM:  return CLS_OPIMM;
      OPC_OP:     return CLS_OP;
      default:    return CLS_ILLEGAL;
    endcase
  endfunction

  function automatic logic [1:0] wb_sel_of(input cls_e c);
    case (c)
      CLS_LOAD:          return WB_LOAD;
      CLS_JAL, CLS_JALR: return WB_PC4;
      CLS_LUI:           return WB_IMM;
      default:           return WB_ALU;
    endcase
  endfunction

endpackage

// File: rtl/core_control_fsm_next_pc_unit.sv
// Combinational next-PC selection for the control sequencer, plus a flag for
// targets that are not 4-byte aligned.
`timescale 1ns/1ps
module next_pc_unit
  import core_ctrl_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] alu_result_i,
  input  logic        taken_br_i,
  input  cls_e        cls_i,
  output logic [31:0] next_pc_o,
  output logic        misalign_o
);

  always_comb begin
    next_pc_o = pc_i + 32'd4;
    case (cls_i)
      CLS_JAL:    next_pc_o = pc_i + imm_i;
      CLS_BRANCH: if (taken_br_i) next_pc_o = pc_i + imm_i;
      CLS_JALR:   next_pc_o = alu_result_i & 32'hFFFF_FFFE;
      default:    ;
    endcase
  end

  // Bit 0 is always clear here, so only bit 1 can break word alignment.
  assign misalign_o = next_pc_o[1];

endmodule

// File: rtl/core_control_fsm.sv
// Multi-cycle RV32I sequencer: owns the PC and walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, trapping illegal opcodes, bad targets and memory timeouts.
`timescale 1ns/1ps
module core_control_fsm
  import core_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          MEM_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        taken_br,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        alu_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic        rf_wr_en,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        fault
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_e        state_q, state_d;
  cls_e          cls_q, cls_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] wait_q, wait_d;

  logic fetch_q, decode_q, alu_q, mem_req_q, mem_we_q, rf_wr_q, fault_q;
  logic [1:0] wb_sel_q;

  logic [31:0] next_pc;
  logic        misalign;

  next_pc_unit u_next_pc (
    .pc_i         (pc_q),
    .imm_i        (imm),
    .alu_result_i (alu_result),
    .taken_br_i   (taken_br),
    .cls_i        (cls_q),
    .next_pc_o    (next_pc),
    .misalign_o   (misalign)
  );

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    pc_d    = pc_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        cls_d  = classify(opcode);
        wait_d = '0;
        if (cls_d == CLS_ILLEGAL)
          state_d = ST_FAULT;
        else if (cls_d == CLS_LOAD || cls_d == CLS_STORE)
          state_d = ST_MEM;
        else
          state_d = ST_WB;
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (cls_q == CLS_LOAD) begin
            state_d = ST_WB;
          end else if (misalign) begin
            state_d = ST_FAULT;
          end else begin
            pc_d    = next_pc;
            state_d = ST_FETCH;
          end
        end else if (wait_q == CW'(MEM_TIMEOUT - 1)) begin
          state_d = ST_FAULT;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      ST_WB: begin
        if (misalign) begin
          state_d = ST_FAULT;
        end else begin
          pc_d    = next_pc;
          state_d = ST_FETCH;
        end
      end
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_FAULT;
    endcase
  end

  // Strobes are registered from the upcoming state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cls_q     <= CLS_ILLEGAL;
      pc_q      <= RESET_PC;
      wait_q    <= '0;
      fetch_q   <= 1'b0;
      decode_q  <= 1'b0;
      alu_q     <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      rf_wr_q   <= 1'b0;
      wb_sel_q  <= WB_ALU;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      pc_q      <= pc_d;
      wait_q    <= wait_d;
      fetch_q   <= (state_d == ST_FETCH);
      decode_q  <= (state_d == ST_DECODE);
      alu_q     <= (state_d == ST_EXEC);
      mem_req_q <= (state_d == ST_MEM);
      mem_we_q  <= (state_d == ST_MEM) && (cls_d == CLS_STORE);
      rf_wr_q   <= (state_d == ST_WB) && (cls_d != CLS_BRANCH);
      wb_sel_q  <= (state_d == ST_WB) ? wb_sel_of(cls_d) : WB_ALU;
      fault_q   <= (state_d == ST_FAULT);
    end
  end

  assign pc        = pc_q;
  assign fetch_en  = fetch_q;
  assign decode_en = decode_q;
  assign alu_en    = alu_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  // A misaligned target aborts the instruction, so its register write is dropped.
  assign rf_wr_en  = rf_wr_q & ~misalign;
  assign wb_sel    = wb_sel_q;
  assign state     = state_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_core_control_fsm.sv
// Directed and randomized bench for core_control_fsm against a per-instruction
// reference model of the PC, write-back and strobe sequence.
`timescale 1ns/1ps
module tb_core_control_fsm;
  import core_ctrl_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0;
  localparam int          TMO    = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  opcode = '0;
  logic        taken_br = 1'b0;
  logic [31:0] imm = '0;
  logic [31:0] alu_result = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] pc;
  logic        fetch_en, decode_en, alu_en, mem_req, mem_we, rf_wr_en, fault;
  logic [1:0]  wb_sel;
  logic [2:0]  state;

  int tests = 0;
  int fails = 0;
  logic [31:0] m_pc = RST_PC;
  bit          m_faulted = 1'b0;

  typedef enum {K_ILL, K_LOAD, K_STORE, K_BR, K_JAL, K_JALR, K_LUI, K_OTHER} kind_t;

  core_control_fsm #(.RESET_PC(RST_PC), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .taken_br(taken_br), .imm(imm),
    .alu_result(alu_result), .mem_ready(mem_ready), .pc(pc), .fetch_en(fetch_en),
    .decode_en(decode_en), .alu_en(alu_en), .mem_req(mem_req), .mem_we(mem_we),
    .rf_wr_en(rf_wr_en), .wb_sel(wb_sel), .state(state), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic kind_t kind_of(input logic [6:0] op);
    case (op)
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b1100011: return K_BR;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b0110111: return K_LUI;
      7'b0010111, 7'b0010011, 7'b0110011: return K_OTHER;
      default:    return K_ILL;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Strobe vector order: fetch, decode, alu, mem_req, mem_we, rf_wr, wb_sel[1:0], fault.
  task automatic expect_cyc(input string tag, input state_e es, input logic [31:0] epc,
                            input logic rw, input logic [1:0] wb, input logic mw);
    logic [8:0] exp_s;
    exp_s = {es == ST_FETCH, es == ST_DECODE, es == ST_EXEC, es == ST_MEM, mw, rw, wb,
             es == ST_FAULT};
    chk({tag, "/state"}, 32'(state), 32'(es));
    chk({tag, "/strobes"}, 32'({fetch_en, decode_en, alu_en, mem_req, mem_we, rf_wr_en,
                                wb_sel, fault}), 32'(exp_s));
    chk({tag, "/pc"}, pc, epc);
  endtask

  task automatic do_reset;
    reset = 1'b0;
    mem_ready = 1'($urandom);
    tick;
    expect_cyc("reset", ST_IDLE, RST_PC, 1'b0, 2'b00, 1'b0);
    reset = 1'b1;
    tick;
    m_pc = RST_PC;
    m_faulted = 1'b0;
  endtask

  task automatic fault_hold(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'($urandom);
      opcode = 7'($urandom);
      tick;
      expect_cyc({tag, "/hold"}, ST_FAULT, m_pc, 1'b0, 2'b00, 1'b0);
    end
  endtask

  // ready_at: MEM cycle (1-based) carrying mem_ready, 0 = never.
  // rst_at: MEM cycle during which reset is pulled low, 0 = never.
  task automatic run_instr(input string tag, input logic [6:0] op, input logic [31:0] im,
                           input logic [31:0] al, input logic tb, input int ready_at,
                           input int rst_at);
    kind_t k;
    logic [31:0] tgt;
    logic [1:0] wbx;
    k = kind_of(op);
    opcode = op; imm = im; alu_result = al; taken_br = tb;
    case (k)
      K_JAL:   tgt = m_pc + im;
      K_BR:    tgt = tb ? m_pc + im : m_pc + 32'd4;
      K_JALR:  tgt = {al[31:1], 1'b0};
      default: tgt = m_pc + 32'd4;
    endcase
    wbx = (k == K_LOAD) ? 2'b01 : (k == K_JAL || k == K_JALR) ? 2'b10 :
          (k == K_LUI) ? 2'b11 : 2'b00;

    mem_ready = 1'($urandom);
    expect_cyc({tag, "/F"}, ST_FETCH, m_pc, 1'b0, 2'b00, 1'b0);
    tick;
    mem_ready = 1'($urandom);
    expect_cyc({tag, "/D"}, ST_DECODE, m_pc, 1'b0, 2'b00, 1'b0);
    tick;
    mem_ready = 1'($urandom);
    expect_cyc({tag, "/E"}, ST_EXEC, m_pc, 1'b0, 2'b00, 1'b0);
    tick;

    if (k == K_ILL) begin
      expect_cyc({tag, "/ill"}, ST_FAULT, m_pc, 1'b0, 2'b00, 1'b0);
      m_faulted = 1'b1;
      return;
    end

    if (k == K_LOAD || k == K_STORE) begin
      for (int n = 1; n <= TMO; n++) begin
        mem_ready = (n == ready_at);
        expect_cyc({tag, "/M"}, ST_MEM, m_pc, 1'b0, 2'b00, k == K_STORE);
        if (n == rst_at) begin
          reset = 1'b0;
          tick;
          expect_cyc({tag, "/rstM"}, ST_IDLE, RST_PC, 1'b0, 2'b00, 1'b0);
          reset = 1'b1;
          tick;
          m_pc = RST_PC;
          return;
        end
        tick;
        if (n == ready_at) break;
        if (n == TMO) begin
          expect_cyc({tag, "/tmo"}, ST_FAULT, m_pc, 1'b0, 2'b00, 1'b0);
          m_faulted = 1'b1;
          return;
        end
      end
      if (k == K_STORE) begin
        m_pc = m_pc + 32'd4;
        return;
      end
    end

    mem_ready = 1'($urandom);
    expect_cyc({tag, "/W"}, ST_WB, m_pc, (k != K_BR) && !tgt[1], wbx, 1'b0);
    tick;
    if (tgt[1]) begin
      expect_cyc({tag, "/mis"}, ST_FAULT, m_pc, 1'b0, 2'b00, 1'b0);
      m_faulted = 1'b1;
    end else begin
      m_pc = tgt;
    end
  endtask

  localparam logic [6:0] ADDI = 7'b0010011, OPR = 7'b0110011, LUI = 7'b0110111,
                         AUIPC = 7'b0010111, BEQ = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, LW = 7'b0000011, SW = 7'b0100011;

  initial begin
    logic [6:0] legal_ops [9];
    logic [6:0] op;
    logic [31:0] im, al;
    int ready;
    legal_ops = '{ADDI, OPR, LUI, AUIPC, BEQ, JAL, JALR, LW, SW};

    do_reset();
    run_instr("addi", ADDI, 32'd21, 32'd21, 1'b0, 0, 0);
    run_instr("op", OPR, 32'h0, 32'h5, 1'b0, 0, 0);
    run_instr("lui", LUI, 32'h1234_5000, 32'h0, 1'b0, 0, 0);
    run_instr("auipc", AUIPC, 32'h40, 32'h0, 1'b0, 0, 0);
    run_instr("beq_t", BEQ, 32'd8, 32'h0, 1'b1, 0, 0);
    run_instr("opimm", ADDI, 32'h7, 32'h0, 1'b1, 0, 0);
    run_instr("jal", JAL, 32'h100, 32'h0, 1'b0, 0, 0);
    run_instr("jalr", JALR, 32'h0, 32'h201, 1'b0, 0, 0);
    chk("jalr_pc", pc, 32'h200);

    do_reset();
    for (int i = 0; i < 4; i++) run_instr("pad", ADDI, 32'h1, 32'h0, 1'b0, 0, 0);
    run_instr("beq_nt", BEQ, 32'd8, 32'h0, 1'b0, 0, 0);
    chk("beq_nt_pc", pc, 32'h14);
    for (int i = 0; i < 2; i++) run_instr("pad", OPR, 32'h0, 32'h0, 1'b0, 0, 0);
    run_instr("jal_mis", JAL, 32'h102, 32'h0, 1'b0, 0, 0);
    fault_hold("jal_mis", 3);

    do_reset();
    run_instr("sw", SW, 32'h8, 32'h100, 1'b0, 3, 0);
    run_instr("lw1", LW, 32'h8, 32'h100, 1'b0, 1, 0);
    run_instr("lw_tmo", LW, 32'h8, 32'h100, 1'b0, 0, 0);
    fault_hold("lw_tmo", 4);

    do_reset();
    run_instr("ill", 7'b1111111, 32'h0, 32'h0, 1'b0, 0, 0);
    fault_hold("ill", 2);

    do_reset();
    run_instr("addi2", ADDI, 32'h1, 32'h0, 1'b0, 0, 0);
    run_instr("lw_rst", LW, 32'h0, 32'h40, 1'b0, 0, 2);

    for (int i = 0; i < 150; i++) begin
      if (m_faulted) begin
        fault_hold("rnd", 2);
        do_reset();
      end
      op = legal_ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 19) == 0) op = 7'($urandom);
      im = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) im[1] = 1'b1;
      al = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) al[1] = 1'b1;
      if ($urandom_range(0, 1) == 0) al[0] = 1'b1;
      ready = ($urandom_range(0, 14) == 0) ? 0 : $urandom_range(1, TMO);
      run_instr("rnd", op, im, al, 1'($urandom), ready, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
